zero_frame_tx: RTL and testbench
================================

# zero_frame_tx

Serial frame transmitter that generates the bit stream consumed by `zero_detector`. It accepts a parallel word through a load/ready handshake and serialises it on `x_out`, one bit per `CLOCK` cycle. Each frame is a two-bit all-zero start marker, then the data MSB first, then a run of stop bits at 1. The line idles at 1, so a zero detector on the far end sees zeros only inside frames. It drives the detector's `x_in` in system benches and loopback tests.

## Interface
- `WIDTH`, default 8: data bits per frame; must be >= 2.
- `STOP_LEN`, default 2: stop bits (value 1) per frame; must be >= 1.

- `CLOCK`  in  1  rising-edge clock; the only clock.
- `t_reset`  in  1  synchronous, active-high reset, sampled on the `CLOCK` rising edge.
- `data_in`  in  WIDTH  word to transmit; sampled only on an accepting edge.
- `load`  in  1  request to transmit `data_in`.
- `ready`  out  1  block can accept `load` in this cycle.
- `x_out`  out  1  serial line; idle level 1.
- `p_state`  out  2  current state: 00 IDLE, 01 START, 10 DATA, 11 STOP.
- `done`  out  1  one-cycle pulse during the last stop bit of each completed frame.

## Operation
- Internal registers: shift register (WIDTH), bit counter (sized for max(WIDTH, STOP_LEN, 2)), state (2 bits).
- `ready` = (state == IDLE) or (state == STOP and the current bit is the last stop bit). Decode it combinationally from the registered state and counter.
- Accept: on a rising edge with `load` = 1, `ready` = 1 and `t_reset` = 0.
  - Capture `data_in` into the shift register.
  - Go to START with counter = 0.
- Without an accept, `load` is ignored and `data_in` is not sampled.
- States:
  - IDLE: `x_out` = 1. Stay here until an accept.
  - START: `x_out` = 0 for exactly 2 cycles, then DATA.
  - DATA: `x_out` = shift register MSB. Shift left once per cycle, for exactly WIDTH cycles, then STOP.
  - STOP: `x_out` = 1 for exactly STOP_LEN cycles. `done` = 1 in the last of them.
    - If an accept occurs at the end of the last stop cycle, go to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Changes to `data_in` after acceptance do not affect the frame in flight.
- Reset:
  - When `t_reset` = 1 at an edge: state = IDLE, `x_out` = 1, `done` = 0, counter = 0, shift register = 0.
  - Reset overrides `load` in the same cycle.
  - Reset mid-frame aborts the frame, with no `done` pulse.
- Reset values: `x_out` = 1, `p_state` = 00, `ready` = 1, `done` = 0.

## Timing
- Every output is a function of registered state only and changes only after a `CLOCK` rising edge. There are no combinational paths from inputs to outputs.
- Accept at edge E:
  - Cycles 1–2 after E: START, `x_out` = 0.
  - Cycles 3 to WIDTH+2: DATA, bit `data_in[WIDTH-1-i]` in cycle 3+i.
  - Cycles WIDTH+3 to WIDTH+2+STOP_LEN: STOP.
- Frame length F = WIDTH + 2 + STOP_LEN cycles (12 for the defaults).
- `done` is high only in cycle F.
- Throughput: one frame per F cycles if `load` is held high.
- Latency from accept edge to first start bit: 1 cycle.

## Test plan
- Reset:
  - Stimulus: hold `t_reset` = 1 for 2 edges with `load` = 1.
  - Required response: `x_out` = 1, `p_state` = 00, `ready` = 1, `done` = 0, and no frame starts.
- Single frame:
  - Stimulus: `data_in` = 8'hA5, `load` pulsed for 1 cycle.
  - Required response: `x_out` = 0,0,1,0,1,0,0,1,0,1,1,1, then 1 while idle.
  - `p_state` = 01×2, 10×8, 11×2, then 00.
  - `done` high only in cycle 12.
- Back-to-back:
  - Stimulus: 8'h00, then 8'hFF presented in the last stop cycle, with `load` held high.
  - Required response: the second frame's start bits follow the first frame's stop bit with no idle cycle.
  - `done` pulses at cycles 12 and 24.
- Load while busy:
  - Stimulus: `load` = 1 with `data_in` = 8'h3C in cycle 5 of an 8'hA5 frame.
  - Required response: `ready` = 0; the A5 bit sequence is unchanged and no second frame follows.
- Reset mid-frame:
  - Stimulus: `t_reset` = 1 in cycle 6 of a frame.
  - Required response: next cycle `x_out` = 1, `p_state` = 00, `ready` = 1, and no `done`.
  - A load on the following edge starts a full, correct frame.
- Loopback:
  - Stimulus: drive `zero_detector` `x_in` from `x_out` with `data_in` = 8'hFF.
  - Required response: the detector sees zeros only in the two start-bit cycles of each frame.

Source files
------------

// File: rtl/zero_frame_tx.sv
// Serial frame transmitter: two zero start bits, WIDTH data bits MSB first,
// then STOP_LEN one-valued stop bits. The line idles high.
module zero_frame_tx #(
    parameter int WIDTH    = 8,
    parameter int STOP_LEN = 2
) (
    input  logic             CLOCK,
    input  logic             t_reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic [1:0]       p_state,
    output logic             done
);

    localparam int MAX_CNT = (WIDTH > STOP_LEN) ? WIDTH : ((STOP_LEN > 2) ? STOP_LEN : 2);
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    localparam logic [CW-1:0] START_LAST = CW'(1);
    localparam logic [CW-1:0] DATA_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_LEN - 1);

    logic [1:0]       state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             last_stop;
    logic             accept;

    assign last_stop = (state_reg == STOP) && (cnt_reg == STOP_LAST);
    assign ready     = (state_reg == IDLE) || last_stop;
    assign accept    = load && ready;
    assign done      = last_stop;
    assign p_state   = state_reg;

    always_comb begin
        x_out = 1'b1;
        case (state_reg)
            START:   x_out = 1'b0;
            DATA:    x_out = shift_reg[WIDTH-1];
            default: x_out = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        case (state_reg)
            START: begin
                if (cnt_reg == START_LAST) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DATA: begin
                shift_next = {shift_reg[WIDTH-2:0], 1'b0};
                if (cnt_reg == DATA_LAST) begin
                    state_next = STOP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            STOP: begin
                if (cnt_reg == STOP_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        // An accept in the last stop cycle chains straight into the next frame.
        if (accept) begin
            state_next = START;
            cnt_next   = '0;
            shift_next = data_in;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (t_reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
        end
    end

endmodule

// File: tb/tb_zero_frame_tx.sv
// Randomised and directed bench for zero_frame_tx, checked every cycle against
// a queue of expected per-cycle line values built from the frame format.
module tb_zero_frame_tx;

    localparam int W  = 8;
    localparam int SL = 2;
    localparam int F  = W + 2 + SL;

    logic         CLOCK = 1'b0;
    logic         t_reset = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         load = 1'b0;
    logic         ready, x_out, done;
    logic [1:0]   p_state;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic       x;
        logic [1:0] st;
        logic       dn;
    } slot_t;

    slot_t q[$];

    zero_frame_tx #(.WIDTH(W), .STOP_LEN(SL)) dut (
        .CLOCK(CLOCK), .t_reset(t_reset), .data_in(data_in), .load(load),
        .ready(ready), .x_out(x_out), .p_state(p_state), .done(done)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Line levels of a whole frame, first cycle in the MSB.
    function automatic logic [F-1:0] frame_bits(input logic [W-1:0] d);
        return {2'b00, d, {SL{1'b1}}};
    endfunction

    // Model: each edge consumes one queued cycle; an accept appends a full frame.
    always @(posedge CLOCK) begin
        bit rdy;
        logic [F-1:0] fb;
        rdy = (q.size() <= 1);
        if (t_reset) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (load && rdy) begin
                fb = frame_bits(data_in);
                for (int i = 0; i < F; i++) begin
                    slot_t s;
                    s.x  = fb[F-1-i];
                    s.st = (i < 2) ? 2'b01 : ((i < W + 2) ? 2'b10 : 2'b11);
                    s.dn = (i == F - 1);
                    q.push_back(s);
                end
            end
        end
    end

    always @(negedge CLOCK) begin
        slot_t e;
        if (chk_en) begin
            e = (q.size() > 0) ? q[0] : slot_t'{x: 1'b1, st: 2'b00, dn: 1'b0};
            check("x_out", 32'(x_out), 32'(e.x));
            check("p_state", 32'(p_state), 32'(e.st));
            check("done", 32'(done), 32'(e.dn));
            check("ready", 32'(ready), 32'(q.size() <= 1));
        end
    end

    task automatic step(input logic r, input logic l, input logic [W-1:0] d);
        t_reset = r;
        load    = l;
        data_in = d;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        logic [F-1:0]   xs;
        logic [2*F-1:0] ss;
        logic [F-1:0]   a5_exp;
        int dn_cnt, dn_c1, dn_c2, zeros, zeros_bad;

        a5_exp = 12'b001010010111;
        check("model_a5_bits", 32'(frame_bits(8'hA5)), 32'(a5_exp));
        check("model_00_bits", 32'(frame_bits(8'h00)), 32'h003);

        // Reset held with load asserted
        step(1'b1, 1'b1, 8'h5A);
        step(1'b1, 1'b1, 8'h5A);
        chk_en = 1'b1;
        check("rst_x", 32'(x_out), 32'd1);
        check("rst_state", 32'(p_state), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        check("rst_no_frame", 32'(p_state), 32'd0);

        // Single A5 frame
        step(1'b0, 1'b1, 8'hA5);
        dn_cnt = 0; dn_c1 = 0;
        for (int c = 1; c <= F; c++) begin
            xs[F-c] = x_out;
            ss[2*(F-c) +: 2] = p_state;
            if (done) begin dn_cnt++; dn_c1 = c; end
            step(1'b0, 1'b0, 8'h00);
        end
        check("a5_bits", 32'(xs), 32'(a5_exp));
        check("a5_states", 32'(ss), 32'b01_01_10_10_10_10_10_10_10_10_11_11);
        check("a5_done_cnt", 32'(dn_cnt), 32'd1);
        check("a5_done_cycle", 32'(dn_c1), 32'(F));
        check("a5_idle_after", 32'({x_out, p_state}), 32'b100);

        // Back-to-back: 00 then FF accepted in the last stop cycle
        step(1'b0, 1'b1, 8'h00);
        dn_cnt = 0; dn_c1 = 0; dn_c2 = 0;
        for (int c = 1; c <= 2 * F; c++) begin
            if (done) begin
                dn_cnt++;
                if (dn_cnt == 1) dn_c1 = c; else dn_c2 = c;
            end
            if (c == F + 1) check("b2b_no_gap", 32'({x_out, p_state}), 32'b001);
            step(1'b0, c <= F, (c == F) ? 8'hFF : 8'h00);
        end
        check("b2b_done_cnt", 32'(dn_cnt), 32'd2);
        check("b2b_done1", 32'(dn_c1), 32'(F));
        check("b2b_done2", 32'(dn_c2), 32'(2 * F));

        // Load while busy is ignored
        step(1'b0, 1'b1, 8'hA5);
        for (int c = 1; c <= F + 2; c++) begin
            xs[F-((c - 1) % F)-1] = (c <= F) ? x_out : xs[F-((c - 1) % F)-1];
            if (c == 5) check("busy_ready", 32'(ready), 32'd0);
            step(1'b0, c == 5, (c == 5) ? 8'h3C : 8'h00);
        end
        check("busy_bits", 32'(xs), 32'(a5_exp));
        check("busy_idle", 32'(p_state), 32'd0);

        // Reset mid-frame, then a full frame
        step(1'b0, 1'b1, 8'hA5);
        for (int c = 1; c <= 6; c++) step(c == 6, 1'b0, 8'h00);
        check("mid_rst_x", 32'(x_out), 32'd1);
        check("mid_rst_state", 32'(p_state), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        step(1'b0, 1'b1, 8'hC3);
        for (int c = 1; c <= F + 1; c++) step(1'b0, 1'b0, 8'h00);

        // Loopback view: with FF data zeros appear only in start cycles
        zeros = 0; zeros_bad = 0;
        step(1'b0, 1'b1, 8'hFF);
        for (int c = 1; c <= 3 * F; c++) begin
            if (x_out == 1'b0) begin
                zeros++;
                if (p_state != 2'b01) zeros_bad++;
            end
            step(1'b0, c < 2 * F || c == 2 * F, 8'hFF);
        end
        check("loop_zeros", 32'(zeros), 32'd6);
        check("loop_zeros_outside", 32'(zeros_bad), 32'd0);
        for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 8'h00);

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            step(($urandom % 64) == 0, ($urandom % 4) == 0, W'($urandom));
        end
        for (int c = 0; c < F + 2; c++) step(1'b0, 1'b0, 8'h00);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
